// File: rtl/fpnorm_pkg.sv
// Shared constants and stage payload type for the 144-bit mantissa normalizer.
package fpnorm_pkg;

   localparam int unsigned MANW = 144;
   localparam int unsigned LEADW = 8;
   localparam int unsigned DEF_EXPW = 16;
   localparam logic [LEADW-1:0] LEAD_NONE = 8'd255;
   localparam logic [LEADW-1:0] LEAD_TOP = 8'd143;

   // Payload at the default exponent width; the top re-declares it locally when EXPW differs.
   typedef struct packed {
      logic [MANW-1:0]     man;
      logic [DEF_EXPW-1:0] exp;
      logic [LEADW-1:0]    sh;
      logic                zero;
      logic                uf;
   } stage_t;

   function automatic int unsigned cmp_width(input int unsigned w);
      return (w > LEADW) ? w : LEADW;
   endfunction

endpackage

// File: rtl/flo144.sv
// Find-last-one over a 144-bit vector: index of the highest set bit, LEAD_NONE when empty.
module flo144
   import fpnorm_pkg::*;
(
   input  logic [MANW-1:0]  man,
   output logic [LEADW-1:0] pos
);

   always_comb begin
      pos = LEAD_NONE;
      for (int i = 0; i < int'(MANW); i++) begin
         if (man[i]) pos = LEADW'(i);
      end
   end

endmodule

// File: rtl/fpnorm144_shl.sv
// 144-bit logarithmic left shifter; amounts of 144 or more shift everything out.
module fpnorm144_shl
   import fpnorm_pkg::*;
(
   input  logic [MANW-1:0]  din,
   input  logic [LEADW-1:0] amt,
   output logic [MANW-1:0]  dout
);

   logic [MANW-1:0] stg;

   always_comb begin
      stg = din;
      for (int k = 0; k < int'(LEADW); k++) begin
         if (amt[k]) stg = stg << (1 << k);
      end
      dout = stg;
   end

endmodule

// File: rtl/fpnorm144.sv
// Three-stage left normalizer for 144-bit mantissas with exponent adjust.
// Define FPNORM144_DENORM_EN to produce denormals on underflow instead of flushing to zero.
module fpnorm144
   import fpnorm_pkg::*;
#(
   parameter int unsigned EXPW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [MANW-1:0] man_i,
   input  logic [EXPW-1:0] exp_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [MANW-1:0] man_o,
   output logic [EXPW-1:0] exp_o,
   output logic            zero_o,
   output logic            uf_o
);

   localparam int unsigned CW = cmp_width(EXPW);

   typedef struct packed {
      logic [MANW-1:0]  man;
      logic [EXPW-1:0]  exp;
      logic [LEADW-1:0] sh;
      logic             zero;
      logic             uf;
   } stage_w_t;

   logic adv;
   logic v1_q, v2_q, v3_q;

   // Single enable for all stages: bubbles travel with the data, nothing collapses.
   assign adv     = ~v3_q | ready_i;
   assign ready_o = adv;
   assign valid_o = v3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (adv) begin
         v1_q <= valid_i;
         v2_q <= v1_q;
         v3_q <= v2_q;
      end
   end

   // S1: capture mantissa, exponent and lead-one position.
   logic [LEADW-1:0] lead;
   logic [MANW-1:0]  man1_q;
   logic [EXPW-1:0]  exp1_q;
   logic [LEADW-1:0] p1_q;

   flo144 u_flo (
      .man (man_i),
      .pos (lead)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         man1_q <= '0;
         exp1_q <= '0;
         p1_q   <= LEAD_NONE;
      end else if (adv && valid_i) begin
         man1_q <= man_i;
         exp1_q <= exp_i;
         p1_q   <= lead;
      end
   end

   // S2: shift amount, exponent adjust and underflow decision.
   logic [LEADW-1:0] sh;
   logic [CW-1:0]    sh_ext, exp_ext, e_ext;
   stage_w_t         s2_d, s2_q;

   always_comb begin
      sh      = LEAD_TOP - p1_q;
      sh_ext  = CW'(sh);
      exp_ext = CW'(exp1_q);
      e_ext   = exp_ext - sh_ext;
      s2_d      = '0;
      s2_d.man  = man1_q;
      if (p1_q == LEAD_NONE) begin
         s2_d.zero = 1'b1;
      end else if (sh_ext <= exp_ext) begin
         s2_d.exp = e_ext[EXPW-1:0];
         s2_d.sh  = sh;
      end else begin
         s2_d.uf = 1'b1;
`ifdef FPNORM144_DENORM_EN
         // exp_i < sh <= 143 here, so the exponent fits the shift field.
         s2_d.sh = exp_ext[LEADW-1:0];
`else
         s2_d.sh = LEAD_NONE;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_q <= '0;
      end else if (adv && v1_q) begin
         s2_q <= s2_d;
      end
   end

   // S3: barrel shift and register outputs.
   logic [MANW-1:0] shifted;

   fpnorm144_shl u_shl (
      .din  (s2_q.man),
      .amt  (s2_q.sh),
      .dout (shifted)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         man_o  <= '0;
         exp_o  <= '0;
         zero_o <= 1'b0;
         uf_o   <= 1'b0;
      end else if (adv && v2_q) begin
         man_o  <= shifted;
         exp_o  <= s2_q.exp;
         zero_o <= s2_q.zero;
         uf_o   <= s2_q.uf;
      end
   end

endmodule

// File: tb/tb_fpnorm144.sv
// Self-checking bench for fpnorm144: directed cases, backpressure, throughput, reset.
module tb_fpnorm144;

   logic          clk, rst;
   logic          valid_i, ready_o, valid_o, ready_i;
   logic [143:0]  man_i, man_o;
   logic [15:0]   exp_i, exp_o;
   logic          zero_o, uf_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [143:0] gm[$], em[$];
   logic [15:0]  ge[$], ee[$];
   logic         gz[$], ez[$], gu[$], eu[$];
   int           gcyc[$];

   fpnorm144 #(.EXPW(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .man_i   (man_i),
      .exp_i   (exp_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .man_o   (man_o),
      .exp_o   (exp_o),
      .zero_o  (zero_o),
      .uf_o    (uf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: normalize by plain arithmetic on the leading-one index.
   task automatic push_model(input logic [143:0] m, input logic [15:0] e);
      int lead = -1;
      int sh;
      for (int i = 143; i >= 0; i--) if (m[i] && lead < 0) lead = i;
      if (lead < 0) begin
         em.push_back('0); ee.push_back('0); ez.push_back(1'b1); eu.push_back(1'b0);
      end else begin
         sh = 143 - lead;
         if (sh <= int'(e)) begin
            em.push_back(m << sh); ee.push_back(16'(int'(e) - sh));
            ez.push_back(1'b0); eu.push_back(1'b0);
         end else begin
`ifdef FPNORM144_DENORM_EN
            em.push_back(m << e);
`else
            em.push_back('0);
`endif
            ee.push_back('0); ez.push_back(1'b0); eu.push_back(1'b1);
         end
      end
   endtask

   task automatic clear_q();
      gm.delete(); ge.delete(); gz.delete(); gu.delete(); gcyc.delete();
      em.delete(); ee.delete(); ez.delete(); eu.delete();
   endtask

   // One clock: drive, note transfers, advance to just after the edge.
   task automatic do_cycle(input logic vi, input logic [143:0] mi, input logic [15:0] ei,
                           input logic ri, output logic acc);
      valid_i = vi; man_i = mi; exp_i = ei; ready_i = ri;
      #1;
      acc = vi & ready_o;
      if (valid_o && ri) begin
         gm.push_back(man_o); ge.push_back(exp_o); gz.push_back(zero_o); gu.push_back(uf_o);
         gcyc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   function automatic logic [143:0] rand_man();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) return '0;
      return t[143:0] >> $urandom_range(0, 143);
   endfunction

   task automatic test_reset();
      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; man_i = '0; exp_i = '0;
      #12;
      total++;
      if (valid_o !== 1'b0 || man_o !== '0 || exp_o !== '0 || zero_o !== 1'b0
          || uf_o !== 1'b0 || ready_o !== 1'b1) begin
         bad++;
         $display("FAIL reset: got v=%b man=%h exp=%h z=%b uf=%b rdy=%b want 0/0/0/0/0/1",
                  valid_o, man_o, exp_o, zero_o, uf_o, ready_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_one(input string name, input logic [143:0] m, input logic [15:0] e,
                          input logic [143:0] xm, input logic [15:0] xe,
                          input logic xz, input logic xu);
      logic acc;
      int   c0;
      clear_q();
      c0 = cyc;
      do_cycle(1'b1, m, e, 1'b1, acc);
      for (int i = 0; i < 6; i++) do_cycle(1'b0, '0, '0, 1'b1, acc);
      total++;
      if (gm.size() != 1) begin
         bad++;
         $display("FAIL %s count: got %0d want 1", name, gm.size());
      end else begin
         total++;
         if (gcyc[0] - c0 != 3) begin
            bad++;
            $display("FAIL %s latency: got %0d want 3", name, gcyc[0] - c0);
         end
         total++;
         if (gm[0] !== xm || ge[0] !== xe || gz[0] !== xz || gu[0] !== xu) begin
            bad++;
            $display("FAIL %s: got man=%h exp=%0d z=%b uf=%b want man=%h exp=%0d z=%b uf=%b",
                     name, gm[0], ge[0], gz[0], gu[0], xm, xe, xz, xu);
         end
      end
   endtask

   task automatic test_directed();
      logic [143:0] one = 144'd1;
      run_one("normalize", one << 100, 16'd1000, one << 143, 16'd957, 1'b0, 1'b0);
      run_one("zero", '0, 16'd77, '0, 16'd0, 1'b1, 1'b0);
      run_one("already_norm", (one << 143) | 144'd5, 16'd5, (one << 143) | 144'd5, 16'd5,
              1'b0, 1'b0);
`ifdef FPNORM144_DENORM_EN
      run_one("underflow", one, 16'd10, one << 10, 16'd0, 1'b0, 1'b1);
      run_one("exp0_uf", one << 142, 16'd0, one << 142, 16'd0, 1'b0, 1'b1);
`else
      run_one("underflow", one, 16'd10, '0, 16'd0, 1'b0, 1'b1);
      run_one("exp0_uf", one << 142, 16'd0, '0, 16'd0, 1'b0, 1'b1);
`endif
      run_one("exact_fit", one, 16'd143, one << 143, 16'd0, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [143:0] bm[6];
      logic [15:0]  be[6];
      logic         acc;
      int           pushed = 0;
      int           stall = 0;
      int           guard = 0;
      clear_q();
      for (int i = 0; i < 6; i++) begin
         bm[i] = rand_man() | 144'd1;
         be[i] = 16'($urandom_range(0, 300));
      end
      for (int i = 0; i < 8; i++) begin
         do_cycle(pushed < 6, bm[pushed % 6], be[pushed % 6], 1'b0, acc);
         if (acc) begin push_model(bm[pushed], be[pushed]); pushed++; end
         ready_i = 1'b0; #1;
         if (valid_o) begin
            stall++;
            if (stall == 1) begin
               total++;
               if (ready_o !== 1'b0) begin
                  bad++;
                  $display("FAIL bp_ready: got %b want 0", ready_o);
               end
            end
            total++;
            if (man_o !== em[0] || exp_o !== ee[0]) begin
               bad++;
               $display("FAIL bp_hold: got man=%h exp=%0d want man=%h exp=%0d",
                        man_o, exp_o, em[0], ee[0]);
            end
         end
      end
      total++;
      if (pushed != 3) begin
         bad++;
         $display("FAIL bp_accepted: got %0d want 3", pushed);
      end
      while (gm.size() < 6 && guard < 40) begin
         do_cycle(pushed < 6, bm[pushed % 6], be[pushed % 6], 1'b1, acc);
         if (acc) begin push_model(bm[pushed], be[pushed]); pushed++; end
         guard++;
      end
      valid_i = 1'b0;
      total++;
      if (gm.size() != 6) begin
         bad++;
         $display("FAIL bp_count: got %0d want 6", gm.size());
      end
      for (int i = 0; i < gm.size() && i < em.size(); i++) begin
         total++;
         if (gm[i] !== em[i] || ge[i] !== ee[i] || gz[i] !== ez[i] || gu[i] !== eu[i]) begin
            bad++;
            $display("FAIL bp_beat%0d: got man=%h exp=%0d z=%b uf=%b want man=%h exp=%0d z=%b uf=%b",
                     i, gm[i], ge[i], gz[i], gu[i], em[i], ee[i], ez[i], eu[i]);
         end
      end
   endtask

   task automatic test_throughput();
      logic [143:0] m;
      logic [15:0]  e;
      logic         acc;
      int           c0;
      clear_q();
      c0 = cyc;
      for (int i = 0; i < 20; i++) begin
         m = rand_man();
         e = 16'($urandom_range(0, 300));
         do_cycle(1'b1, m, e, 1'b1, acc);
         total++;
         if (acc !== 1'b1) begin
            bad++;
            $display("FAIL tp_accept%0d: got %b want 1", i, acc);
         end
         push_model(m, e);
      end
      for (int i = 0; i < 6; i++) do_cycle(1'b0, '0, '0, 1'b1, acc);
      total++;
      if (gm.size() != 20) begin
         bad++;
         $display("FAIL tp_count: got %0d want 20", gm.size());
      end
      for (int i = 0; i < gm.size() && i < em.size(); i++) begin
         total++;
         if (gcyc[i] != c0 + 3 + i || gm[i] !== em[i] || ge[i] !== ee[i]
             || gz[i] !== ez[i] || gu[i] !== eu[i]) begin
            bad++;
            $display("FAIL tp_beat%0d: got cyc=%0d man=%h exp=%0d z=%b uf=%b want cyc=%0d man=%h exp=%0d z=%b uf=%b",
                     i, gcyc[i], gm[i], ge[i], gz[i], gu[i], c0 + 3 + i, em[i], ee[i], ez[i], eu[i]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic [143:0] m;
      logic [15:0]  e;
      logic         acc;
      int           c0;
      clear_q();
      for (int i = 0; i < 3; i++) do_cycle(1'b1, rand_man() | 144'd3, 16'd200, 1'b1, acc);
      valid_i = 1'b0;
      #3 rst = 1'b1;
      #1;
      total++;
      if (valid_o !== 1'b0 || man_o !== '0 || exp_o !== '0 || zero_o !== 1'b0
          || uf_o !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid: got v=%b man=%h exp=%0d z=%b uf=%b want all 0",
                  valid_o, man_o, exp_o, zero_o, uf_o);
      end
      #1 rst = 1'b0;
      clear_q();
      m = rand_man() | (144'd1 << 60);
      e = 16'd500;
      push_model(m, e);
      c0 = cyc;
      do_cycle(1'b1, m, e, 1'b1, acc);
      for (int i = 0; i < 8; i++) do_cycle(1'b0, '0, '0, 1'b1, acc);
      total++;
      if (gm.size() != 1) begin
         bad++;
         $display("FAIL rst_post_count: got %0d want 1", gm.size());
      end else begin
         total++;
         if (gcyc[0] - c0 != 3 || gm[0] !== em[0] || ge[0] !== ee[0] || gu[0] !== eu[0]) begin
            bad++;
            $display("FAIL rst_post: got lat=%0d man=%h exp=%0d uf=%b want lat=3 man=%h exp=%0d uf=%b",
                     gcyc[0] - c0, gm[0], ge[0], gu[0], em[0], ee[0], eu[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_throughput();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpnorm144.md
# fpnorm144

Pipelined left-normalizer for 144-bit floating-point mantissas, consuming the leading-one position produced by the `flo144` find-last-one (255 = no bit set). It sits directly downstream of `flo144` in the FP add/multiply datapath, after the raw significand is formed and before rounding. It shifts the mantissa so its leading one lands in bit 143 and reduces the biased exponent by the same amount. It also handles zero and underflow.

## Interface
- `EXPW`, default 16: biased exponent width.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `valid_i`  in  1: input beat valid.
- `ready_o`  out  1: block accepts a beat this cycle.
- `man_i`  in  144: unnormalized mantissa.
- `exp_i`  in  EXPW: biased exponent of `man_i` as if bit 143 were the leading one.
- `valid_o`  out  1: output beat valid.
- `ready_i`  in  1: downstream accepts the output beat.
- `man_o`  out  144: normalized mantissa.
- `exp_o`  out  EXPW: adjusted exponent.
- `zero_o`  out  1: input mantissa was zero.
- `uf_o`  out  1: required shift exceeded `exp_i` (underflow).

## Operation
- Handshake and pipeline enable:
  - `adv = ~valid_o | ready_i`. `ready_o = adv`.
  - All three stages advance together when `adv` is high and hold otherwise.
  - A beat transfers on input when `valid_i & ready_o`, and on output when `valid_o & ready_i`.
  - Bubbles are not collapsed. A stage's valid bit follows its predecessor's valid bit on `adv`.
- S1: register `man_i` and `exp_i`. Compute the lead-one position `p` (8 bits) through `flo144` on `man_i`.
- S2:
  - If `p == 255`: mark zero.
  - Otherwise: `sh = 143 - p` (8 bits, 0..143). Compare `sh` against `exp_i`, zero-extended to `max(EXPW,8)`.
  - If `sh <= exp_i`: `e = exp_i - sh`, `uf = 0`.
  - Otherwise, underflow handling is selected by configuration (see below).
- S3:
  - Barrel-shift the mantissa left by the final shift amount, filling with zeros.
  - Register `man_o`, `exp_o`, `zero_o`, `uf_o`.
- Zero input: `man_o = 0`, `exp_o = 0`, `zero_o = 1`, `uf_o = 0`.
- Already normalized input (bit 143 set): `sh = 0`, so `man_o = man_i` and `exp_o = exp_i`.
- `exp_i = 0` with nonzero `man_i` and `sh > 0` is an underflow case.
- `zero_o` and `uf_o` are never both 1.
- Arithmetic: all exponent arithmetic is unsigned, and no wrap-around is permitted. The underflow path prevents a negative exponent.

## Timing
- Latency is 3 cycles from input transfer to `valid_o`, when there is no stall.
- Throughput is 1 beat per cycle while `ready_i` is held high.
- Output data is stable while `valid_o & ~ready_i`.
- `ready_o` is combinational from `valid_o` and `ready_i` only.
- Reset:
  - All stage valid bits clear, so `valid_o = 0`.
  - `man_o`, `exp_o`, `zero_o`, `uf_o` reset to 0.
  - `ready_o = 1` out of reset.
- Reset asserted mid-operation discards all in-flight beats immediately (asynchronous). No partial output is produced.
- Simultaneous input accept and output drain in the same cycle is required at full throughput.

## Configuration
- `FPNORM144_DENORM_EN` defined, on underflow (`sh > exp_i`):
  - shift by `exp_i` only, giving a denormal result;
  - `exp_o = 0`, `uf_o = 1`.
- `FPNORM144_DENORM_EN` undefined, on underflow: flush to zero.
  - `man_o = 0`, `exp_o = 0`, `uf_o = 1`, `zero_o = 0`.
- Normal and zero paths are identical in both builds.

## Structure
- Shared package `fpnorm_pkg` holds:
  - `MANW = 144`;
  - `LEAD_NONE = 8'd255`;
  - a typedef for the stage payload struct (mantissa, exponent, shift, zero flag, uf flag).
- The package is sized by `EXPW` through a parameterized struct or by local use of the package constants.
- One natural sub-module is `fpnorm144_shl`: a 144-bit left barrel shifter with an 8-bit amount, amounts ≥ 144 yielding 0.
- `flo144` is instantiated in S1.

## Test plan
- **Normalize:** `man_i = 1<<100`, `exp_i = 1000` → after 3 cycles `man_o = 1<<143`, `exp_o = 957`, `zero_o = 0`, `uf_o = 0`.
- **Zero and already normalized:**
  - `man_i = 0`, `exp_i = 77` → `man_o = 0`, `exp_o = 0`, `zero_o = 1`.
  - `man_i = 1<<143 | 5`, `exp_i = 5` → unchanged output.
- **Underflow:** `man_i = 1`, `exp_i = 10`.
  - With `FPNORM144_DENORM_EN`: `man_o = 1<<10`, `exp_o = 0`, `uf_o = 1`.
  - Without: `man_o = 0`, `exp_o = 0`, `uf_o = 1`.
- **Backpressure:**
  - Stream 6 beats with `ready_i = 0` from cycle 2 → `ready_o` drops once `valid_o` rises, and the beat is held stable.
  - Release `ready_i` → all 6 beats emerge in order with no loss or duplication.
- **Full throughput:** `valid_i = 1` and `ready_i = 1` for 20 cycles with random mantissas → one result per cycle, each matching the reference model (shift = 143 − leading-one index).
- **Reset mid-stream:** assert `rst` with 3 beats in flight → `valid_o = 0` and outputs 0 immediately. Post-reset beats emerge with latency 3 and no stale data.
